// File: rtl/mem_byte_arbiter.sv
// mem_byte_arbiter
//  Shares one byte-wide memory (sync write, combinational read) between a
//  32-bit instruction-fetch port and a 32-bit data port. Each granted word
//  access becomes four big-endian byte beats (lane 0 = bits 31:24 at the
//  lowest byte address of the word), followed by a one-cycle acknowledge.
module mem_byte_arbiter #(
  parameter int AW    = 14,
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  // instruction-fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_adr,
  output logic          i_ack,
  output logic [31:0]   i_dat,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_sel,
  input  logic [AW-1:0] d_adr,
  input  logic [31:0]   d_dat_w,
  output logic          d_ack,
  output logic [31:0]   d_dat_r,
  // byte-wide memory
  output logic [AW-1:0] mem_adr,
  output logic [7:0]    mem_dat_o,
  input  logic [7:0]    mem_dat_i,
  output logic          mem_en,
  output logic          mem_we
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // ------------------------------------------------------------------
  // Lane helpers: beat b addresses lane b, which lives in bits
  // [31-8b -: 8] and is enabled by sel[3-b].
  // ------------------------------------------------------------------
  function automatic logic f_lane_en(input logic [3:0] sel, input logic [1:0] beat);
    logic en;
    case (beat)
      2'd0:    en = sel[3];
      2'd1:    en = sel[2];
      2'd2:    en = sel[1];
      2'd3:    en = sel[0];
      default: en = 1'b0;
    endcase
    return en;
  endfunction

  function automatic logic [7:0] f_lane_get(input logic [31:0] word, input logic [1:0] beat);
    logic [7:0] b;
    case (beat)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] f_lane_put(input logic [31:0] word, input logic [1:0] beat,
                                             input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (beat)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      2'd3:    w[7:0]   = b;
      default: w = word;
    endcase
    return w;
  endfunction

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_beat;
  logic          r_last_grant;
  logic          r_port;
  logic [AW-1:0] r_adr;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_wdata;
  logic [31:0]   r_buf;
  logic [31:0]   r_i_dat;
  logic [31:0]   r_d_dat_r;

  logic          w_grant_vld;
  logic          w_grant_port;
  logic          w_lane_en;
  logic          w_beat_last;
  logic [31:0]   w_buf_nxt;

  assign w_lane_en   = f_lane_en(r_sel, r_beat);
  assign w_beat_last = (r_beat == 2'd3);
  assign i_dat       = r_i_dat;
  assign d_dat_r     = r_d_dat_r;

  // Arbitration: single requester wins outright; on contention either
  // alternate against the previous winner or always favour the data port.
  always_comb begin
    w_grant_vld  = 1'b0;
    w_grant_port = PORT_I;
    if (i_req && d_req) begin
      w_grant_vld = 1'b1;
      if (RR_EN == 1'b1) begin
        w_grant_port = (r_last_grant == PORT_I) ? PORT_D : PORT_I;
      end else begin
        w_grant_port = PORT_D;
      end
    end else if (d_req) begin
      w_grant_vld  = 1'b1;
      w_grant_port = PORT_D;
    end else if (i_req) begin
      w_grant_vld  = 1'b1;
      w_grant_port = PORT_I;
    end else begin
      w_grant_vld  = 1'b0;
      w_grant_port = PORT_I;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> XFER (4 beats) -> ACK -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = ST_XFER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (w_beat_last) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_XFER;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: memory strobes and acks come from registers only, so a
  // request never reaches the memory pins combinationally.
  always_comb begin
    mem_adr   = '0;
    mem_dat_o = 8'h00;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    case (r_state)
      ST_XFER: begin
        mem_adr   = {r_adr[AW-1:2], r_beat};
        mem_en    = w_lane_en;
        mem_we    = r_we & w_lane_en;
        mem_dat_o = f_lane_get(r_wdata, r_beat);
      end
      ST_ACK: begin
        if (r_port == PORT_D) begin
          d_ack = 1'b1;
        end else begin
          i_ack = 1'b1;
        end
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Read assembly: the current beat's byte, or zero for a disabled lane.
  always_comb begin
    if (w_lane_en) begin
      w_buf_nxt = f_lane_put(r_buf, r_beat, mem_dat_i);
    end else begin
      w_buf_nxt = f_lane_put(r_buf, r_beat, 8'h00);
    end
  end

  // Latch the granted request; port inputs are ignored until the next IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_port  <= PORT_I;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_sel   <= 4'b0000;
      r_wdata <= 32'h0000_0000;
    end else if (r_state == ST_IDLE && w_grant_vld) begin
      r_port <= w_grant_port;
      if (w_grant_port == PORT_D) begin
        r_adr   <= d_adr;
        r_we    <= d_we;
        r_sel   <= d_sel;
        r_wdata <= d_dat_w;
      end else begin
        r_adr   <= i_adr;
        r_we    <= 1'b0;
        r_sel   <= 4'b1111;
        r_wdata <= 32'h0000_0000;
      end
    end
  end

  // Beat counter: cleared on grant, advanced every XFER cycle (wraps after 3).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= 2'd0;
    end else if (r_state == ST_IDLE && w_grant_vld) begin
      r_beat <= 2'd0;
    end else if (r_state == ST_XFER) begin
      r_beat <= r_beat + 2'd1;
    end
  end

  // Remember which port was served last, for round-robin fairness.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= PORT_I;
    end else if (r_state == ST_ACK) begin
      r_last_grant <= r_port;
    end
  end

  // Collect read bytes in a private buffer and publish the whole word to
  // the owning port only when the last beat lands, so each port's read
  // data stays stable until its next read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf     <= 32'h0000_0000;
      r_i_dat   <= 32'h0000_0000;
      r_d_dat_r <= 32'h0000_0000;
    end else if (r_state == ST_IDLE && w_grant_vld) begin
      r_buf <= 32'h0000_0000;
    end else if (r_state == ST_XFER) begin
      r_buf <= w_buf_nxt;
      if (w_beat_last && !r_we) begin
        if (r_port == PORT_D) begin
          r_d_dat_r <= w_buf_nxt;
        end else begin
          r_i_dat <= w_buf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_byte_arbiter.sv
// tb_mem_byte_arbiter
//  Drives the arbiter against a byte-array memory. Expected values come from
//  a hand-computed vector table, a byte-level reference memory for random
//  traffic, and the arbitration/latency rules for the contention sequences.
module tb_mem_byte_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  // round-robin instance
  logic        i_req, i_ack, d_req, d_we, d_ack, mem_en, mem_we;
  logic [13:0] i_adr, d_adr, mem_adr;
  logic [31:0] i_dat, d_dat_w, d_dat_r;
  logic [3:0]  d_sel;
  logic [7:0]  mem_dat_o, mem_dat_i;

  // fixed-priority instance
  logic        b_i_req, b_i_ack, b_d_req, b_d_we, b_d_ack, b_mem_en, b_mem_we;
  logic [13:0] b_i_adr, b_d_adr, b_mem_adr;
  logic [31:0] b_i_dat, b_d_dat_w, b_d_dat_r;
  logic [3:0]  b_d_sel;
  logic [7:0]  b_mem_dat_o, b_mem_dat_i;

  logic [7:0]  mem_a   [0:16383];
  logic [7:0]  mem_b   [0:16383];
  logic [7:0]  ref_mem [0:16383];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_byte_arbiter #(.AW(14), .RR_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_dat(i_dat),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_adr(d_adr), .d_dat_w(d_dat_w),
    .d_ack(d_ack), .d_dat_r(d_dat_r),
    .mem_adr(mem_adr), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_en(mem_en), .mem_we(mem_we)
  );

  mem_byte_arbiter #(.AW(14), .RR_EN(1'b0)) u_dut_fixed (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_adr(b_i_adr), .i_ack(b_i_ack), .i_dat(b_i_dat),
    .d_req(b_d_req), .d_we(b_d_we), .d_sel(b_d_sel), .d_adr(b_d_adr), .d_dat_w(b_d_dat_w),
    .d_ack(b_d_ack), .d_dat_r(b_d_dat_r),
    .mem_adr(b_mem_adr), .mem_dat_o(b_mem_dat_o), .mem_dat_i(b_mem_dat_i),
    .mem_en(b_mem_en), .mem_we(b_mem_we)
  );

  // Byte memories: combinational read, write on the clock edge.
  assign mem_dat_i   = mem_a[mem_adr];
  assign b_mem_dat_i = mem_b[b_mem_adr];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_a[mem_adr] <= mem_dat_o;
    if (b_mem_en && b_mem_we) mem_b[b_mem_adr] <= b_mem_dat_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_a(input logic [13:0] a);
    logic [13:0] b;
    b = {a[13:2], 2'b00};
    return {mem_a[b], mem_a[b + 14'd1], mem_a[b + 14'd2], mem_a[b + 14'd3]};
  endfunction

  // Reference read: selected lanes from the reference memory, others zero.
  function automatic logic [31:0] model_read(input logic [3:0] sel, input logic [13:0] a);
    logic [31:0] r;
    logic [13:0] b;
    r = 32'h0;
    b = {a[13:2], 2'b00};
    for (int l = 0; l < 4; l++)
      if (sel[3 - l]) r[31 - 8 * l -: 8] = ref_mem[b + 14'(l)];
    return r;
  endfunction

  task automatic model_write(input logic [3:0] sel, input logic [13:0] a, input logic [31:0] dat);
    logic [13:0] b;
    b = {a[13:2], 2'b00};
    for (int l = 0; l < 4; l++)
      if (sel[3 - l]) ref_mem[b + 14'(l)] = dat[31 - 8 * l -: 8];
  endtask

  // One transaction on the round-robin instance, started at a negedge.
  task automatic run_xfer(input logic is_d, input logic we, input logic [3:0] sel,
                          input logic [13:0] adr, input logic [31:0] wdat,
                          input logic [31:0] exp_rd, input string tag);
    int          cyc;
    logic        got, adr_bad, other_ack;
    logic [3:0]  en_pat, exp_en;
    logic [31:0] i_before, d_before;
    cyc = 0; got = 1'b0; adr_bad = 1'b0; other_ack = 1'b0; en_pat = 4'h0;
    exp_en   = is_d ? sel : 4'hF;
    i_before = i_dat;
    d_before = d_dat_r;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_sel = sel; d_adr = adr; d_dat_w = wdat;
    end else begin
      i_req = 1'b1; i_adr = adr;
    end
    while (!got && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc >= 1 && cyc <= 4) begin
        en_pat[4 - cyc] = mem_en;
        if (mem_en && (mem_adr !== {adr[13:2], 2'(cyc - 1)})) adr_bad = 1'b1;
      end
      if (cyc == 1) begin
        // disturb the port inputs; the latched copies must be used
        d_adr = 14'($urandom); d_sel = 4'($urandom); d_dat_w = $urandom;
        d_we = 1'($urandom); i_adr = 14'($urandom);
      end
      if (is_d ? i_ack : d_ack) other_ack = 1'b1;
      if (is_d ? d_ack : i_ack) got = 1'b1;
    end
    chk({tag, " latency"}, 32'(cyc), 32'd5);
    chk({tag, " beat enables"}, {28'h0, en_pat}, {28'h0, exp_en});
    chk({tag, " beat address"}, {31'h0, adr_bad}, 32'h0);
    chk({tag, " wrong-port ack"}, {31'h0, other_ack}, 32'h0);
    if (is_d && !we) chk({tag, " d_dat_r"}, d_dat_r, exp_rd);
    if (!is_d)       chk({tag, " i_dat"}, i_dat, exp_rd);
    if (is_d)        chk({tag, " i_dat held"}, i_dat, i_before);
    if (!is_d || we) chk({tag, " d_dat_r held"}, d_dat_r, d_before);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " ack one cycle"}, {30'h0, i_ack, d_ack}, 32'h0);
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  sel;
    logic [13:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic        is_d, we;
    logic [3:0]  sel;
    logic [13:0] adr;
    logic [31:0] wdat, exp;
    int          bad, a_acks, b_d, b_i, last_cyc;
    logic        exp_d;

    for (int k = 0; k < 16384; k++) begin
      mem_a[k] = 8'h00; mem_b[k] = 8'h00; ref_mem[k] = 8'h00;
    end
    rst = 1'b0;
    i_req = 1'b0; i_adr = 14'h0; d_req = 1'b0; d_we = 1'b0; d_sel = 4'h0;
    d_adr = 14'h0; d_dat_w = 32'h0;
    b_i_req = 1'b0; b_i_adr = 14'h0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_sel = 4'h0;
    b_d_adr = 14'h0; b_d_dat_w = 32'h0;

    // ---- reset state ----
    @(negedge clk);
    chk("reset acks/en/we", {28'h0, i_ack, d_ack, mem_en, mem_we}, 32'h0);
    chk("reset mem_adr", {18'h0, mem_adr}, 32'h0);
    chk("reset mem_dat_o", {24'h0, mem_dat_o}, 32'h0);
    chk("reset i_dat", i_dat, 32'h0);
    chk("reset d_dat_r", d_dat_r, 32'h0);
    rst = 1'b1;

    // ---- reset during beat 1 of a data write ----
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_adr = 14'h0300; d_dat_w = 32'hA1B2C3D4;
    @(posedge clk); @(negedge clk);
    chk("mid-reset beat0 en", {31'h0, mem_en & mem_we}, 32'h1);
    @(posedge clk); @(negedge clk);
    chk("mid-reset beat1 en", {31'h0, mem_en & mem_we}, 32'h1);
    rst = 1'b0; d_req = 1'b0;
    #1;
    chk("mid-reset en/we/acks", {28'h0, i_ack, d_ack, mem_en, mem_we}, 32'h0);
    chk("mid-reset mem_adr", {18'h0, mem_adr}, 32'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    chk("mid-reset memory", {mem_a[14'h300], mem_a[14'h301], mem_a[14'h302], mem_a[14'h303]},
        32'hA100_0000);
    ref_mem[14'h300] = 8'hA1;

    // ---- directed vector table ----
    vecs[0] = '{1'b1, 1'b1, 4'b1111, 14'h0104, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b0, 4'b1111, 14'h0106, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 4'b0101, 14'h0104, 32'h11223344, 32'h0,        32'hDE22BE44};
    vecs[3] = '{1'b1, 1'b0, 4'b1111, 14'h0105, 32'h0,        32'hDE22BE44, 32'hDE22BE44};
    vecs[4] = '{1'b1, 1'b0, 4'b0000, 14'h0104, 32'h0,        32'h00000000, 32'hDE22BE44};
    vecs[5] = '{1'b1, 1'b0, 4'b1001, 14'h0107, 32'h0,        32'hDE000044, 32'hDE22BE44};
    vecs[6] = '{1'b0, 1'b0, 4'b1111, 14'h0104, 32'h0,        32'hDE22BE44, 32'hDE22BE44};
    vecs[7] = '{1'b1, 1'b1, 4'b1010, 14'h0104, 32'hCAFEF00D, 32'h0,        32'hCA22F044};
    vecs[8] = '{1'b0, 1'b0, 4'b1111, 14'h0107, 32'h0,        32'hCA22F044, 32'hCA22F044};
    for (int v = 0; v < 9; v++) begin
      run_xfer(vecs[v].is_d, vecs[v].we, vecs[v].sel, vecs[v].adr, vecs[v].wdat,
               vecs[v].exp_rd, $sformatf("vec%0d", v));
      if (vecs[v].is_d && vecs[v].we) model_write(vecs[v].sel, vecs[v].adr, vecs[v].wdat);
      chk($sformatf("vec%0d memory", v), word_a(vecs[v].adr), vecs[v].exp_mem);
    end

    // ---- random traffic against the reference memory ----
    for (int t = 0; t < 40; t++) begin
      is_d = 1'($urandom_range(0, 1));
      we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      sel  = is_d ? 4'($urandom_range(0, 15)) : 4'hF;
      adr  = 14'h0200 + 14'($urandom_range(0, 63));
      wdat = $urandom;
      exp  = model_read(sel, adr);
      run_xfer(is_d, we, sel, adr, wdat, exp, $sformatf("rand%0d", t));
      if (we) model_write(sel, adr, wdat);
      chk($sformatf("rand%0d memory", t), word_a(adr), model_read(4'hF, adr));
    end
    bad = 0;
    for (int k = 14'h0100; k < 14'h0400; k++)
      if (mem_a[k] !== ref_mem[k]) bad++;
    chk("memory window", 32'(bad), 32'h0);

    // ---- both ports requesting continuously ----
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    i_req = 1'b1; i_adr = 14'h0104; d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_adr = 14'h0200;
    b_i_req = 1'b1; b_i_adr = 14'h0104; b_d_req = 1'b1; b_d_we = 1'b0; b_d_sel = 4'hF;
    b_d_adr = 14'h0200;
    a_acks = 0; b_d = 0; b_i = 0; last_cyc = 0; exp_d = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); @(negedge clk);
      if (i_ack || d_ack) begin
        chk($sformatf("rr ack%0d port", a_acks), {30'h0, i_ack, d_ack}, {30'h0, ~exp_d, exp_d});
        if (a_acks == 0) chk("rr first latency", 32'(c), 32'd5);
        else             chk($sformatf("rr ack%0d spacing", a_acks), 32'(c - last_cyc), 32'd6);
        last_cyc = c;
        a_acks++;
        exp_d = ~exp_d;
      end
      if (b_d_ack) b_d++;
      if (b_i_ack) b_i++;
    end
    chk("rr ack count", 32'(a_acks), 32'd5);
    chk("fixed D ack count", 32'(b_d), 32'd5);
    chk("fixed I ack count", 32'(b_i), 32'd0);
    i_req = 1'b0; d_req = 1'b0; b_i_req = 1'b0; b_d_req = 1'b0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
